// File: rtl/branch_pred_ctrl_pkg.sv
// Shared predictor package.
// Holds the 2-bit saturating counter encodings, the default history and
// statistics widths, and the counter step function used by each PHT entry.
package branch_pred_ctrl_pkg;

   localparam int unsigned GHR_W_DEF = 4;
   localparam int unsigned CNT_W_DEF = 16;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } cnt2_e;

   // One saturating step up (taken) or down (not taken).
   function automatic cnt2_e sat_step(input cnt2_e c, input logic up);
      cnt2_e r;
      r = c;
      if (up) begin
         if (c != ST) r = cnt2_e'(c + 2'd1);
      end else begin
         if (c != SNT) r = cnt2_e'(c - 2'd1);
      end
      return r;
   endfunction

endpackage

// File: rtl/branch_pred_ctrl_if.sv
// Predictor bus between the pipeline (master) and the predictor (slave).
// Fetch side: branchF, stallF, pcF in; predTakenF, idxF, historyF out.
// Execute side: branchE, isTakenE, predTakenE, idxE, histE in;
// mispredictE, branchCount, missCount out.
interface branch_pred_ctrl_if
   import branch_pred_ctrl_pkg::*;
#(
   parameter int unsigned GHR_W = GHR_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
);
   logic             branchF;
   logic             stallF;
   logic [31:0]      pcF;
   logic             predTakenF;
   logic [GHR_W-1:0] idxF;
   logic [GHR_W-1:0] historyF;

   logic             branchE;
   logic             isTakenE;
   logic             predTakenE;
   logic [GHR_W-1:0] idxE;
   logic [GHR_W-1:0] histE;
   logic             mispredictE;
   logic [CNT_W-1:0] branchCount;
   logic [CNT_W-1:0] missCount;

   modport master (
      output branchF, stallF, pcF, branchE, isTakenE, predTakenE, idxE, histE,
      input  predTakenF, idxF, historyF, mispredictE, branchCount, missCount
   );

   modport slave (
      input  branchF, stallF, pcF, branchE, isTakenE, predTakenE, idxE, histE,
      output predTakenF, idxF, historyF, mispredictE, branchCount, missCount
   );
endinterface

// File: rtl/sat_counter2.sv
// 2-bit saturating up/down counter, one per PHT entry.
// Ports: clk, reset (async, active-high, resets to WNT), i_en (step this
// cycle), i_up (1 = toward ST, 0 = toward SNT), o_cnt (current value).
module sat_counter2
   import branch_pred_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_en,
   input  logic       i_up,
   output logic [1:0] o_cnt
);
   cnt2_e r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= WNT;
      end else if (i_en) begin
         r_cnt <= sat_step(r_cnt, i_up);
      end
   end

   assign o_cnt = r_cnt;
endmodule

// File: rtl/branch_pred_ctrl.sv
// Gshare branch predictor control.
// Ports: clk, reset (async, active-high), bp (slave side of the predictor
// bus). Fetch looks up PHT[pc ^ ghr] combinationally and speculatively
// shifts the prediction into the global history; execute trains the PHT,
// restores history from the returned checkpoint on a mispredict, and
// keeps saturating branch/miss statistics.
module branch_pred_ctrl
   import branch_pred_ctrl_pkg::*;
#(
   parameter int unsigned GHR_W = GHR_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   branch_pred_ctrl_if.slave  bp
);
   localparam int unsigned PHT_N = 1 << GHR_W;

   logic [GHR_W-1:0] r_ghr;
   logic [GHR_W-1:0] w_ghr_d;
   logic [CNT_W-1:0] r_branch_cnt;
   logic [CNT_W-1:0] r_miss_cnt;
   logic [GHR_W-1:0] w_idx_f;
   logic             w_pred_f;
   logic             w_mispredict;
   logic [1:0]       w_pht [PHT_N];

   // PC bits and checkpoint MSB that do not take part in indexing.
   logic w_unused;
   assign w_unused = ^{bp.pcF[31:GHR_W+2], bp.pcF[1:0], bp.histE[GHR_W-1]};

   for (genvar g = 0; g < PHT_N; g++) begin : g_pht
      sat_counter2 u_cnt (
         .clk   (clk),
         .reset (reset),
         .i_en  (bp.branchE && (bp.idxE == GHR_W'(g))),
         .i_up  (bp.isTakenE),
         .o_cnt (w_pht[g])
      );
   end

   // Read returns the pre-edge counter, so a same-cycle write to the
   // same entry is only seen on the following lookup.
   assign w_idx_f      = bp.pcF[GHR_W+1:2] ^ r_ghr;
   assign w_pred_f     = bp.branchF & w_pht[w_idx_f][1];
   assign w_mispredict = bp.branchE & (bp.predTakenE ^ bp.isTakenE);

   always_comb begin
      w_ghr_d = r_ghr;
      if (w_mispredict) begin
         // Restore wins over a speculative fetch shift in the same cycle.
         w_ghr_d = {bp.histE[GHR_W-2:0], bp.isTakenE};
      end else if (bp.branchF && !bp.stallF) begin
         w_ghr_d = {r_ghr[GHR_W-2:0], w_pred_f};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ghr        <= '0;
         r_branch_cnt <= '0;
         r_miss_cnt   <= '0;
      end else begin
         r_ghr <= w_ghr_d;
         if (bp.branchE && (r_branch_cnt != '1)) begin
            r_branch_cnt <= r_branch_cnt + CNT_W'(1);
         end
         if (w_mispredict && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + CNT_W'(1);
         end
      end
   end

   assign bp.predTakenF  = w_pred_f;
   assign bp.idxF        = w_idx_f;
   assign bp.historyF    = r_ghr;
   assign bp.mispredictE = w_mispredict;
   assign bp.branchCount = r_branch_cnt;
   assign bp.missCount   = r_miss_cnt;
endmodule
